// File: rtl/aes_pkg.sv
// Shared AES decryption types, constants and byte-level helpers.
// Block layout is FIPS-197 column-major: byte 0 sits in bits [127:120].
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int NUM_ROUNDS  = 10;

    typedef enum logic [2:0] {
        IDLE,
        ARK0,
        ROUND,
        FINAL,
        DONE
    } ctrl_state_t;

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[b];
    endfunction

    // Row r rotates right by r columns.
    function automatic logic [AES_BLOCK_W-1:0] inv_shift_rows(
        input logic [AES_BLOCK_W-1:0] s
    );
        logic [AES_BLOCK_W-1:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127-8*(row+4*c) -: 8] =
                    s[127-8*(row+4*((c-row+4)%4)) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [AES_BLOCK_W-1:0] inv_sub_bytes(
        input logic [AES_BLOCK_W-1:0] s
    );
        logic [AES_BLOCK_W-1:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_inv_round_datapath.sv
// Combinational inverse round: shared InvShiftRows/InvSubBytes/AddRoundKey
// feeding both the final-round result and the gated InvMixColumns.
module aes_inv_round_datapath
    import aes_pkg::*;
(
    input  logic [AES_BLOCK_W-1:0] stateIn,
    input  logic [AES_BLOCK_W-1:0] roundKey,
    input  logic                   mixEnable,
    output logic [AES_BLOCK_W-1:0] roundOut,
    output logic [AES_BLOCK_W-1:0] finalOut
);

    logic [AES_BLOCK_W-1:0] subbed;

    assign subbed   = inv_sub_bytes(inv_shift_rows(stateIn));
    assign finalOut = subbed ^ roundKey;

    inv_mix_columns uMix (
        .startTransition (mixEnable),
        .dataIn          (finalOut),
        .dataOut         (roundOut)
    );

endmodule

// File: rtl/inv_mix_columns.sv
// Combinational AES InvMixColumns; output forced to zero unless
// startTransition is high.
module inv_mix_columns (
    input  logic         startTransition,
    input  logic [127:0] dataIn,
    output logic [127:0] dataOut
);

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mixCol(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2    = xt(a[i]);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    always_comb begin
        dataOut = '0;
        if (startTransition) begin
            for (int c = 0; c < 4; c++) begin
                dataOut[127-32*c -: 32] = mixCol(dataIn[127-32*c -: 32]);
            end
        end
    end

endmodule

// File: rtl/aes_inv_round_controller.sv
// Iterative AES-128 decryption sequencer: one round per cycle, walking
// round keys 10 down to 0 with a start/done handshake.
module aes_inv_round_controller #(
    parameter int NUM_ROUNDS     = aes_pkg::NUM_ROUNDS,
    parameter int KEY_ADDR_WIDTH = 4
) (
    input  logic                      clock50MHz,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      keysReady,
    input  logic [127:0]              cipherText,
    output logic [KEY_ADDR_WIDTH-1:0] roundKeyAddr,
    input  logic [127:0]              roundKeyData,
    output logic                      busy,
    output logic                      done,
    output logic                      abortErr,
    output logic [127:0]              plainText
);

    import aes_pkg::*;

    localparam logic [KEY_ADDR_WIDTH-1:0] ADDR_TOP =
        KEY_ADDR_WIDTH'(NUM_ROUNDS);
    localparam logic [KEY_ADDR_WIDTH-1:0] ADDR_ONE =
        KEY_ADDR_WIDTH'(1);

    ctrl_state_t               fsm, fsmNext;
    logic [127:0]              aesState, aesStateNext;
    logic [127:0]              plainNext;
    logic [KEY_ADDR_WIDTH-1:0] addrNext;
    logic                      busyNext, doneNext, abortNext;
    logic                      mixEnable;
    logic [127:0]              roundOut, finalOut;

    aes_inv_round_datapath uDatapath (
        .stateIn   (aesState),
        .roundKey  (roundKeyData),
        .mixEnable (mixEnable),
        .roundOut  (roundOut),
        .finalOut  (finalOut)
    );

    always_comb begin
        fsmNext      = fsm;
        aesStateNext = aesState;
        plainNext    = plainText;
        addrNext     = roundKeyAddr;
        busyNext     = busy;
        doneNext     = 1'b0;
        abortNext    = 1'b0;
        mixEnable    = 1'b0;
        unique case (fsm)
            IDLE: begin
                if (start && keysReady) begin
                    aesStateNext = cipherText;
                    addrNext     = ADDR_TOP;
                    busyNext     = 1'b1;
                    fsmNext      = ARK0;
                end
            end
            ARK0: begin
                aesStateNext = aesState ^ roundKeyData;
                addrNext     = roundKeyAddr - ADDR_ONE;
                fsmNext      = ROUND;
            end
            ROUND: begin
                mixEnable    = 1'b1;
                aesStateNext = roundOut;
                addrNext     = roundKeyAddr - ADDR_ONE;
                if (roundKeyAddr == ADDR_ONE) begin
                    fsmNext = FINAL;
                end
            end
            FINAL: begin
                plainNext = finalOut;
                busyNext  = 1'b0;
                doneNext  = 1'b1;
                addrNext  = ADDR_TOP;
                fsmNext   = DONE;
            end
            DONE: begin
                addrNext = ADDR_TOP;
                fsmNext  = IDLE;
            end
            default: fsmNext = IDLE;
        endcase
        // Losing the key schedule mid-run abandons the block.
        if (fsm inside {ARK0, ROUND, FINAL} && !keysReady) begin
            fsmNext      = IDLE;
            aesStateNext = aesState;
            plainNext    = plainText;
            addrNext     = ADDR_TOP;
            busyNext     = 1'b0;
            doneNext     = 1'b0;
            abortNext    = 1'b1;
        end
    end

    always_ff @(posedge clock50MHz or posedge reset) begin
        if (reset) begin
            fsm          <= IDLE;
            aesState     <= '0;
            roundKeyAddr <= ADDR_TOP;
            busy         <= 1'b0;
            done         <= 1'b0;
            abortErr     <= 1'b0;
            plainText    <= '0;
        end else begin
            fsm          <= fsmNext;
            aesState     <= aesStateNext;
            roundKeyAddr <= addrNext;
            busy         <= busyNext;
            done         <= doneNext;
            abortErr     <= abortNext;
            plainText    <= plainNext;
        end
    end

endmodule
